// File: rtl/tinyriscv_pkg.sv
// Shared pipeline-control encodings and bus widths for the tinyriscv core.
// Also holds the state type used by the pipeline scheduler.
package tinyriscv_pkg;

    localparam int InstAddrBus   = 32;
    localparam int Hold_Flag_Bus = 3;

    localparam logic [Hold_Flag_Bus-1:0] Pipe_Flow  = 3'b000;
    localparam logic [Hold_Flag_Bus-1:0] Pipe_Stall = 3'b001;
    localparam logic [Hold_Flag_Bus-1:0] Pipe_Clear = 3'b111;

    typedef enum logic [1:0] {
        S_FLOW,
        S_STALL,
        S_FLUSH
    } pipe_sched_state_e;

endpackage

// File: rtl/sat_cnt.sv
// Event counter that sticks at all-ones instead of wrapping.
// A clear request takes priority over a simultaneous increment.
module sat_cnt #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_sched.sv
// Pipeline scheduler: forwards jumps to pc_reg, drives flow/stall/clear to the
// pipeline registers, and watches for stalls that run too long.
module pipe_sched import tinyriscv_pkg::*; #(
    parameter int FLUSH_LEN     = 2,
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     jump_flag_i,
    input  logic [InstAddrBus-1:0]   jump_addr_i,
    input  logic                     hold_ex_i,
    input  logic                     hold_bus_i,
    input  logic                     hold_clint_i,
    input  logic                     stall_clr_i,
    output logic [Hold_Flag_Bus-1:0] hold_flag_o,
    output logic                     jump_flag_o,
    output logic [InstAddrBus-1:0]   jump_addr_o,
    output logic                     stall_timeout_o,
    output logic [31:0]              flush_cnt_o,
    output logic [31:0]              stall_cnt_o
);

    localparam logic [3:0]  FlushLoad = 4'(FLUSH_LEN - 1);
    localparam logic [15:0] RunMax    = 16'(STALL_TIMEOUT);

    pipe_sched_state_e state_q, state_d;
    logic [3:0]        flush_q, flush_d;
    logic [15:0]       run_q, run_d;
    logic              timeout_q, timeout_d;
    logic              hold_req;
    logic              stall_now;

    assign hold_req = hold_ex_i | hold_bus_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FLOW;
            flush_q   <= '0;
            run_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flush_q   <= flush_d;
            run_q     <= run_d;
            timeout_q <= timeout_d;
        end
    end

    // A new jump always restarts the flush window; it never extends a pending one.
    always_comb begin
        state_d = state_q;
        flush_d = flush_q;
        if (jump_flag_i) begin
            flush_d = FlushLoad;
            if (FLUSH_LEN > 1) begin
                state_d = S_FLUSH;
            end else begin
                state_d = hold_req ? S_STALL : S_FLOW;
            end
        end else begin
            case (state_q)
                S_FLOW, S_STALL: state_d = hold_req ? S_STALL : S_FLOW;
                S_FLUSH: begin
                    if (flush_q <= 4'd1) begin
                        flush_d = '0;
                        state_d = hold_req ? S_STALL : S_FLOW;
                    end else begin
                        flush_d = flush_q - 4'd1;
                    end
                end
                default: state_d = S_FLOW;
            endcase
        end
    end

    // Reset is folded in so the pipeline sees Clear for the whole reset window.
    always_comb begin
        hold_flag_o = Pipe_Flow;
        if (rst || jump_flag_i || hold_clint_i || (state_q == S_FLUSH)) begin
            hold_flag_o = Pipe_Clear;
        end else if (hold_req) begin
            hold_flag_o = Pipe_Stall;
        end
    end

    assign stall_now = (hold_flag_o == Pipe_Stall);

    always_comb begin
        run_d     = '0;
        timeout_d = timeout_q;
        if (stall_clr_i) begin
            run_d     = '0;
            timeout_d = 1'b0;
        end else begin
            if (stall_now) begin
                run_d = (run_q >= RunMax) ? RunMax : run_q + 16'd1;
            end
            if (run_d == RunMax) begin
                timeout_d = 1'b1;
            end
        end
    end

    sat_cnt #(.WIDTH(32)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (jump_flag_i),
        .clr_i (stall_clr_i),
        .cnt_o (flush_cnt_o)
    );

    sat_cnt #(.WIDTH(32)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (stall_now),
        .clr_i (stall_clr_i),
        .cnt_o (stall_cnt_o)
    );

    assign jump_flag_o     = jump_flag_i;
    assign jump_addr_o     = jump_addr_i;
    assign stall_timeout_o = timeout_q;

endmodule

// File: doc/pipe_sched.md
PIPE_SCHED -- requirements
Module: pipe_sched

Interface
REQ-001 SHALL have parameter FLUSH_LEN, default 2, meaning the number of consecutive cycles Pipe_Clear is driven per accepted jump (legal 1..15).
REQ-002 SHALL have parameter STALL_TIMEOUT, default 1024, meaning the number of consecutive stall cycles that raises stall_timeout_o (legal 2..65535).
REQ-003 SHALL have port clk, input, 1, the single clock; all state SHALL update on the rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port jump_flag_i, input, 1, branch/jump taken from ex.
REQ-006 SHALL have port jump_addr_i, input, InstAddrBus, jump target from ex.
REQ-007 SHALL have port hold_ex_i, input, 1, multi-cycle ex operation in progress.
REQ-008 SHALL have port hold_bus_i, input, 1, instruction/data bus not granted.
REQ-009 SHALL have port hold_clint_i, input, 1, interrupt entry/return hold from clint.
REQ-010 SHALL have port stall_clr_i, input, 1, clears stall_timeout_o and both counters.
REQ-011 SHALL have port hold_flag_o, output, Hold_Flag_Bus, pipeline control to pc_reg/if_id/id_ex.
REQ-012 SHALL have port jump_flag_o / jump_addr_o, output, 1 / InstAddrBus, PC redirect to pc_reg.
REQ-013 SHALL have port stall_timeout_o, output, 1, sticky stall-timeout indication.
REQ-014 SHALL have ports flush_cnt_o and stall_cnt_o, output, 32 each, saturating event counters.

Function
REQ-015 SHALL implement FSM states S_FLOW, S_STALL, S_FLUSH.
REQ-016 jump_flag_o/jump_addr_o SHALL equal jump_flag_i/jump_addr_i combinationally (zero latency).
REQ-017 hold_flag_o SHALL be Pipe_Clear when jump_flag_i=1, hold_clint_i=1, or state=S_FLUSH; else Pipe_Stall when hold_ex_i|hold_bus_i; else Pipe_Flow.
REQ-018 jump_flag_i=1 in any state SHALL load flush counter with FLUSH_LEN-1 and enter S_FLUSH if FLUSH_LEN>1; FLUSH_LEN=1 SHALL return to S_FLOW/S_STALL per hold inputs.
REQ-019 In S_FLUSH, counter SHALL decrement each cycle; on reaching 0 with no new jump, next state SHALL be S_STALL if hold_ex_i|hold_bus_i, else S_FLOW.
REQ-020 A jump during S_FLUSH SHALL reload the counter (restart, no accumulation).
REQ-021 S_FLOW->S_STALL when hold_ex_i|hold_bus_i and no jump; S_STALL->S_FLOW when both deassert; hold_clint_i SHALL not change state.
REQ-022 Stall-run counter (16 bit) SHALL increment each cycle hold_flag_o=Pipe_Stall, reset to 0 on any other cycle, saturate at STALL_TIMEOUT.
REQ-023 stall_timeout_o SHALL set in the cycle after the run counter reaches STALL_TIMEOUT and remain set until stall_clr_i or reset.
REQ-024 flush_cnt_o SHALL increment once per cycle jump_flag_i=1; stall_cnt_o once per cycle hold_flag_o=Pipe_Stall; both saturate at 0xFFFF_FFFF.
REQ-025 stall_clr_i SHALL win over a simultaneous increment or timeout set (result 0 / cleared).

Reset
REQ-026 rst=1 SHALL force S_FLOW, flush counter 0, run counter 0, stall_timeout_o=0, flush_cnt_o=0, stall_cnt_o=0, immediately and independent of clk.
REQ-027 During reset hold_flag_o SHALL be Pipe_Clear; jump_flag_o SHALL follow REQ-016.
REQ-028 Reset mid-flush SHALL abandon the flush; first cycle after deassertion follows REQ-017 from S_FLOW.

Structure
REQ-029 tinyriscv_pkg SHALL hold the pipe-control encodings Pipe_Flow, Pipe_Stall, Pipe_Clear (width Hold_Flag_Bus) and the state enum pipe_sched_state_e.
REQ-030 Saturating counters SHALL use one sub-module sat_cnt (parameter width; inc, clr inputs), instantiated for flush_cnt_o and stall_cnt_o.
REQ-031 No other sub-modules; FLUSH_LEN/STALL_TIMEOUT stay module parameters.

Verification
REQ-032 Jump pulse 1 cycle, addr 0x0000_0100, FLUSH_LEN=2 -> jump_flag_o same cycle with 0x100; hold_flag_o Clear,Clear then Flow; flush_cnt_o=1.
REQ-033 Jump at cycle 0 and cycle 1, FLUSH_LEN=3 -> Clear for cycles 0..3, Flow at cycle 4; flush_cnt_o=2.
REQ-034 hold_ex_i high 5 cycles with hold_clint_i high in cycle 2 -> Stall,Stall,Clear,Stall,Stall,Flow; stall_cnt_o=4.
REQ-035 hold_bus_i held, STALL_TIMEOUT=8 -> stall_timeout_o rises after 8th stall cycle, stays high after release; stall_clr_i pulse -> 0, counters 0.
REQ-036 rst asserted mid-flush with hold_ex_i=1 -> outputs reset asynchronously; after release hold_flag_o=Stall, state S_STALL.
